// File: rtl/fmap_buf_ctrl.sv
// Clear/load/scan sequencer for the 30x30 zero-padded feature-map buffer.
// FMAP_CLEAR_EN adds the buffer-clearing CLEAR phase ahead of LOAD.
module fmap_buf_ctrl #(
    parameter int WIDTH  = 9,
    parameter int DIM    = 30,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              tap_valid,
    output logic [3:0]        tap_idx,
    output logic              win_last,
    output logic              frame_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0]     IN_LAST = CW'(DIM - 3);
    localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(DIM + 1);
    localparam logic [ADDR_W-1:0] A_RSKIP = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_KROW  = ADDR_W'(DIM - 2);
`ifdef FMAP_CLEAR_EN
    localparam logic [ADDR_W-1:0] A_CLAST = ADDR_W'(DIM * DIM - 1);
`endif

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CONV, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] waddr, base, raddr;
    logic [CW-1:0]     row, col, ox, oy;
    logic [3:0]        tap;
    logic [1:0]        kx;
    logic              tv_q, wl_q, fl_q;
    logic [3:0]        ti_q;
    logic              accept, load_end, win_end, conv_end, clear_end;

    assign accept   = (state == LOAD) && in_valid;
    assign load_end = accept && (row == IN_LAST) && (col == IN_LAST);
    assign win_end  = (tap == 4'd8);
    assign conv_end = (state == CONV) && win_end
                      && (ox == IN_LAST) && (oy == IN_LAST);
`ifdef FMAP_CLEAR_EN
    assign clear_end = (state == CLEAR) && (waddr == A_CLAST);
`else
    assign clear_end = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
`ifdef FMAP_CLEAR_EN
            IDLE:  if (start) state_nxt = CLEAR;
`else
            IDLE:  if (start) state_nxt = LOAD;
`endif
            CLEAR: if (clear_end) state_nxt = LOAD;
            LOAD:  if (load_end) state_nxt = CONV;
            CONV:  if (conv_end) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high so the reset cycle is quiet too.
    always_comb begin
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_re     = 1'b0;
        mem_raddr  = '0;
        tap_valid  = 1'b0;
        tap_idx    = '0;
        win_last   = 1'b0;
        frame_last = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        if (!rst) begin
            in_ready   = (state == LOAD);
            mem_we     = (state == CLEAR) || accept;
            mem_waddr  = mem_we ? waddr : '0;
            mem_wdata  = accept ? in_data : '0;
            mem_re     = (state == CONV);
            mem_raddr  = mem_re ? raddr : '0;
            tap_valid  = tv_q;
            tap_idx    = ti_q;
            win_last   = wl_q;
            frame_last = fl_q;
            busy       = (state != IDLE);
            done       = (state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr <= '0;
            row   <= '0;
            col   <= '0;
            base  <= '0;
            raddr <= '0;
            tap   <= '0;
            kx    <= '0;
            ox    <= '0;
            oy    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
`ifdef FMAP_CLEAR_EN
                    waddr <= '0;
`else
                    waddr <= A_FIRST;
`endif
                    row   <= '0;
                    col   <= '0;
                    base  <= '0;
                    raddr <= '0;
                    tap   <= '0;
                    kx    <= '0;
                    ox    <= '0;
                    oy    <= '0;
                end
                CLEAR: waddr <= clear_end ? A_FIRST : waddr + 1'b1;
                LOAD: if (accept) begin
                    if (col == IN_LAST) begin
                        col   <= '0;
                        row   <= row + 1'b1;
                        waddr <= waddr + A_RSKIP;
                    end else begin
                        col   <= col + 1'b1;
                        waddr <= waddr + 1'b1;
                    end
                end
                CONV: begin
                    if (win_end) begin
                        tap <= '0;
                        kx  <= '0;
                        // Next window base: step right, or wrap to next row.
                        if (ox == IN_LAST) begin
                            ox    <= '0;
                            oy    <= oy + 1'b1;
                            base  <= base + A_RSKIP;
                            raddr <= base + A_RSKIP;
                        end else begin
                            ox    <= ox + 1'b1;
                            base  <= base + 1'b1;
                            raddr <= base + 1'b1;
                        end
                    end else if (kx == 2'd2) begin
                        kx    <= '0;
                        tap   <= tap + 1'b1;
                        raddr <= raddr + A_KROW;
                    end else begin
                        kx    <= kx + 1'b1;
                        tap   <= tap + 1'b1;
                        raddr <= raddr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tv_q <= 1'b0;
            ti_q <= '0;
            wl_q <= 1'b0;
            fl_q <= 1'b0;
        end else begin
            tv_q <= (state == CONV);
            ti_q <= (state == CONV) ? tap : 4'd0;
            wl_q <= (state == CONV) && win_end;
            fl_q <= conv_end;
        end
    end

endmodule

// File: tb/tb_fmap_buf_ctrl.sv
// Directed bench for fmap_buf_ctrl: reset, clear, load, conv scan, restart.
// Clear-phase checks follow the FMAP_CLEAR_EN build option.
module tb_fmap_buf_ctrl;

    logic       clk, rst, start, in_valid;
    logic [8:0] in_data;
    logic       in_ready, mem_we, mem_re;
    logic [9:0] mem_waddr, mem_raddr;
    logic [8:0] mem_wdata;
    logic       tap_valid, win_last, frame_last, busy, done;
    logic [3:0] tap_idx;
    logic [40:0] outs;

    int checks = 0;
    int passes = 0;
    int raddr_log [7056];

    fmap_buf_ctrl #(.WIDTH(9), .DIM(30), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .tap_valid(tap_valid), .tap_idx(tap_idx),
        .win_last(win_last), .frame_last(frame_last),
        .busy(busy), .done(done)
    );

    assign outs = {in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
                   tap_valid, tap_idx, win_last, frame_last, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (outs !== 41'd0) $display("FAIL reset_cycle: got %h want 0", outs);
        else passes++;
        rst = 1'b0;
        next_cycle();
        #1;
        checks++;
        if (outs !== 41'd0) $display("FAIL reset_after: got %h want 0", outs);
        else passes++;
    endtask

    // Pulses start and walks to the first LOAD cycle without advancing it.
    task automatic test_start();
        int errs;
        int nwr;
        start = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL start_idle_busy: got %b want 0", busy);
        else passes++;
        next_cycle();
        start = 1'b0;
`ifdef FMAP_CLEAR_EN
        errs = 0;
        nwr = 0;
        for (int i = 0; i < 900; i++) begin
            #1;
            if (mem_we === 1'b1) nwr++;
            if (mem_we !== 1'b1 || mem_waddr !== 10'(i) || mem_wdata !== 9'd0
                || in_ready !== 1'b0 || mem_re !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL clear_seq: i=%0d we=%b addr=%0d data=%0d want we=1 addr=%0d data=0",
                             i, mem_we, mem_waddr, mem_wdata, i);
                errs++;
            end
            next_cycle();
        end
        checks++;
        if (errs != 0) $display("FAIL clear_seq_errs: got %0d want 0", errs);
        else passes++;
        checks++;
        if (nwr != 900) $display("FAIL clear_count: got %0d want 900", nwr);
        else passes++;
`endif
        #1;
        checks++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1)
            $display("FAIL load_entry: ready=%b we=%b busy=%b want 1 0 1",
                     in_ready, mem_we, busy);
        else passes++;
    endtask

    task automatic test_load(input bit gaps);
        int pix, errs, nwr, cyc, exp_a;
        int a0, a27, a28, a783;
        bit v;
        logic [8:0] d;
        pix = 0; errs = 0; nwr = 0; cyc = 0;
        a0 = -1; a27 = -1; a28 = -1; a783 = -1;
        while (pix < 784 && cyc < 5000) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = 9'((pix * 37 + 5) % 512);
            in_valid = v;
            in_data = d;
            #1;
            exp_a = ((pix / 28) + 1) * 30 + (pix % 28) + 1;
            if (mem_we === 1'b1) nwr++;
            if (v) begin
                if (pix == 0)   a0 = int'(mem_waddr);
                if (pix == 27)  a27 = int'(mem_waddr);
                if (pix == 28)  a28 = int'(mem_waddr);
                if (pix == 783) a783 = int'(mem_waddr);
                if (mem_we !== 1'b1 || mem_waddr !== 10'(exp_a)
                    || mem_wdata !== d || mem_re !== 1'b0) begin
                    if (errs == 0)
                        $display("FAIL load_seq: pix=%0d we=%b addr=%0d data=%0d want 1 %0d %0d",
                                 pix, mem_we, mem_waddr, mem_wdata, exp_a, d);
                    errs++;
                end
                pix++;
            end else if (mem_we !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL load_gap: pix=%0d we=%b want 0", pix, mem_we);
                errs++;
            end
            next_cycle();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (pix != 784) $display("FAIL load_bound: got %0d pixels want 784", pix);
        else passes++;
        checks++;
        if (errs != 0) $display("FAIL load_errs: got %0d want 0", errs);
        else passes++;
        checks++;
        if (nwr != 784) $display("FAIL load_count: got %0d want 784", nwr);
        else passes++;
        checks++;
        if (a0 != 31 || a27 != 58 || a28 != 61 || a783 != 868)
            $display("FAIL load_corners: got %0d %0d %0d %0d want 31 58 61 868",
                     a0, a27, a28, a783);
        else passes++;
    endtask

    task automatic test_conv();
        int errs, w, t, e;
        int first_w [9];
        int last_w [9];
        first_w = '{0, 1, 2, 30, 31, 32, 60, 61, 62};
        last_w  = '{837, 838, 839, 867, 868, 869, 897, 898, 899};
        errs = 0;
        for (int n = 0; n < 7056; n++) begin
            start = (n == 100 || n == 5000);
            #1;
            w = n / 9;
            t = n % 9;
            e = ((w / 28) + (t / 3)) * 30 + (w % 28) + (t % 3);
            raddr_log[n] = int'(mem_raddr);
            if (mem_re !== 1'b1 || mem_raddr !== 10'(e) || mem_we !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL conv_seq: n=%0d re=%b addr=%0d we=%b want 1 %0d 0",
                             n, mem_re, mem_raddr, mem_we, e);
                errs++;
            end
            if (n == 0) begin
                checks++;
                if (tap_valid !== 1'b0) $display("FAIL conv_lag: tap_valid=%b want 0", tap_valid);
                else passes++;
            end else begin
                t = (n - 1) % 9;
                if (tap_valid !== 1'b1 || tap_idx !== 4'(t) || win_last !== (t == 8)
                    || frame_last !== 1'b0 || done !== 1'b0) begin
                    if (errs == 0)
                        $display("FAIL conv_tag: n=%0d v=%b idx=%0d wl=%b fl=%b want 1 %0d %b 0",
                                 n, tap_valid, tap_idx, win_last, frame_last, t, t == 8);
                    errs++;
                end
            end
            next_cycle();
        end
        start = 1'b0;
        checks++;
        if (errs != 0) $display("FAIL conv_errs: got %0d want 0", errs);
        else passes++;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (raddr_log[k] != first_w[k] || raddr_log[7047 + k] != last_w[k])
                $display("FAIL conv_window k=%0d: got %0d/%0d want %0d/%0d", k,
                         raddr_log[k], raddr_log[7047 + k], first_w[k], last_w[k]);
            else passes++;
        end
        checks++;
        if (raddr_log[9] != 1) $display("FAIL conv_win2: got %0d want 1", raddr_log[9]);
        else passes++;
        #1;
        checks++;
        if (mem_re !== 1'b0 || tap_valid !== 1'b1 || tap_idx !== 4'd8 || win_last !== 1'b1
            || frame_last !== 1'b1 || done !== 1'b1 || busy !== 1'b1)
            $display("FAIL done_cycle: re=%b v=%b idx=%0d wl=%b fl=%b done=%b busy=%b want 0 1 8 1 1 1 1",
                     mem_re, tap_valid, tap_idx, win_last, frame_last, done, busy);
        else passes++;
        next_cycle();
        #1;
        checks++;
        if (outs !== 41'd0) $display("FAIL idle_after_done: got %h want 0", outs);
        else passes++;
    endtask

    task automatic test_reset_mid_load();
        test_start();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = 9'(i);
            next_cycle();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 41'd0) $display("FAIL midrst_cycle: got %h want 0", outs);
        else passes++;
        next_cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (outs !== 41'd0) $display("FAIL midrst_after: got %h want 0", outs);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_load(1'b0);
        test_conv();
        test_reset_mid_load();
        test_start();
        test_load(1'b1);
        test_conv();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fmap_buf_ctrl.md
# fmap_buf_ctrl

Sequencer for the 30x30 zero-padded feature-map buffer in the conv stage. It optionally clears the buffer, then streams a 28x28 input map into the buffer interior (rows/cols 1..28). It then raster-scans all 784 3x3 windows, issuing nine read addresses per window and tagging the returned data for the downstream MAC array. It sits between the pixel source and the buffer/MAC pair and owns every buffer port.

## Interface
- WIDTH, 9: pixel width; the controller drives mem_wdata.
- DIM, 30: padded side length; the interior side is DIM-2.
- ADDR_W, 10: buffer address width; must satisfy 2^ADDR_W >= DIM*DIM.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start; honoured only in IDLE.
- in_valid  in  1  input pixel valid.
- in_data  in  WIDTH  input pixel, raster order.
- in_ready  out  1  pixel accepted when in_valid & in_ready.
- mem_we  out  1  buffer write enable.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  WIDTH  write data.
- mem_re  out  1  buffer read enable; read data is valid 1 cycle later.
- mem_raddr  out  ADDR_W  read address.
- tap_valid  out  1  buffer read data present this cycle.
- tap_idx  out  4  tap index 0..8, computed as ky*3+kx.
- win_last  out  1  tap_valid & tap_idx==8.
- frame_last  out  1  final tap of final window.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- States and transitions:
  - IDLE → CLEAR on start.
  - CLEAR → LOAD after DIM*DIM writes.
  - LOAD → CONV after 784 accepted pixels.
  - CONV → DONE after 7056 reads.
  - DONE → IDLE unconditionally.
- CLEAR:
  - mem_we=1 and mem_wdata=0 every cycle.
  - mem_waddr steps 0..899, one address per cycle.
- LOAD:
  - in_ready=1.
  - mem_we = in_valid, mem_wdata = in_data.
  - Pixel (r,c), with r,c in 0..27, is written to address (r+1)*DIM + (c+1).
  - The address advances only on acceptance: +1 within a row, +3 at row end to skip two border columns.
  - in_valid gaps stall the controller with no write issued.
- CONV:
  - Output windows are (oy,ox), each 0..27, in raster order. Taps are (ky,kx), each 0..2, in raster order.
  - mem_re=1 every cycle, mem_raddr = (oy+ky)*DIM + (ox+kx).
  - Addresses come from incrementing base/offset counters; no multiplier.
  - There is no backpressure: the MAC array accepts one tap per cycle.
- tap_valid, tap_idx, win_last and frame_last are registered copies of the read-issue qualifiers, delayed 1 cycle to align with the read data.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored; in_ready=0 there.
- Reset:
  - Returns to IDLE from any state.
  - All outputs are 0 in the reset cycle and the cycle after.
  - Counters are cleared.
  - A partially loaded frame is abandoned and the next start restarts from the beginning.

## Timing
- Reset values: every output is 0.
- The start pulse is sampled in cycle 0; the first CLEAR write occurs in cycle 1.
- The first LOAD cycle is cycle DIM*DIM+1, which is cycle 901.
- CONV begins the cycle after the 784th acceptance.
- The first read is issued in the first CONV cycle. The matching tap_valid (tap_idx=0) appears 1 cycle later.
- The last read is issued in cycle T, which is the last CONV cycle.
- In cycle T+1 the controller is in DONE:
  - tap_valid, win_last and frame_last are high.
  - done is high for exactly 1 cycle.
- busy falls in cycle T+2, and start is accepted from T+2.
- mem_we and mem_re are never high in the same cycle.

## Configuration
- FMAP_CLEAR_EN:
  - Defined: the CLEAR state exists as described.
  - Undefined: IDLE → LOAD directly on start, and in_ready is high from cycle 1. The border cells are never written, so the buffer's power-up/initial contents must already hold zeros.

## Test plan
- Start with FMAP_CLEAR_EN defined: exactly 900 writes of 0 to addresses 0..899, then in_ready rises in cycle 901.
- LOAD with continuous in_valid:
  - Pixel 0 goes to addr 31, pixel 27 to 58, pixel 28 to 61.
  - Pixel 783 goes to 868.
  - Exactly 784 writes occur.
- Random in_valid gaps during LOAD: no write in gap cycles, and the address sequence is identical to the gap-free case.
- CONV read addresses:
  - First window: 0,1,2,30,31,32,60,61,62.
  - Second window starts at 1.
  - Last window: 837,838,839,867,868,869,897,898,899.
  - tap_valid lags mem_re by 1 cycle; frame_last and done coincide.
- rst asserted mid-LOAD after 100 pixels:
  - Next cycle: IDLE, outputs 0.
  - A new start replays the full sequence from the beginning.
- start pulses during CONV are ignored. FMAP_CLEAR_EN undefined: in_ready is high in cycle 1 and no CLEAR writes occur.
